// File: rtl/bp_cfg_loader_if.sv
// rtl/bp_cfg_loader_if.sv - uncached config link command/response bundle
interface bp_cfg_loader_if #(
  parameter int msg_width_p = 115
);
  logic [msg_width_p-1:0] mem_cmd;
  logic                   mem_cmd_v;
  logic                   mem_cmd_ready;
  logic [msg_width_p-1:0] mem_resp;
  logic                   mem_resp_v;
  logic                   mem_resp_yumi;

  modport master (
    output mem_cmd, mem_cmd_v, mem_resp_yumi,
    input  mem_cmd_ready, mem_resp, mem_resp_v
  );

  modport slave (
    input  mem_cmd, mem_cmd_v, mem_resp_yumi,
    output mem_cmd_ready, mem_resp, mem_resp_v
  );
endinterface

// File: rtl/bp_cfg_loader.sv
// rtl/bp_cfg_loader.sv - boot-time config loader driving uncached cfg commands
module bp_cfg_loader #(
  parameter int                 paddr_width_p     = 40,
  parameter logic [paddr_width_p-1:0] cfg_base_addr_p = 'h0020_0000,
  parameter int                 cfg_data_width_p  = 64,
  parameter int                 cce_instr_width_p = 64,
  parameter int                 ucode_entries_p   = 256,
  parameter logic [38:0]        npc_boot_p        = 39'h00_8000_0000,
  parameter bit                 skip_ucode_p      = 1'b0,
  localparam int ucode_addr_width_lp = (ucode_entries_p > 1) ? $clog2(ucode_entries_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  bp_cfg_loader_if.master                mem_if,
  output logic [ucode_addr_width_lp-1:0] ucode_addr_o,
  input  logic [cce_instr_width_p-1:0]   ucode_data_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);

  // Message layout, MSB first: {msg_type, addr, size, payload, data}
  localparam int mt_width_lp      = 4;
  localparam int size_width_lp    = 3;
  localparam int payload_width_lp = 4;
  localparam int msg_width_lp     = mt_width_lp + paddr_width_p + size_width_lp
                                    + payload_width_lp + cfg_data_width_p;

  localparam logic [mt_width_lp-1:0]   e_cce_mem_uc_rd   = 4'd2;
  localparam logic [mt_width_lp-1:0]   e_cce_mem_uc_wr   = 4'd3;
  localparam logic [size_width_lp-1:0] e_mem_msg_size_8  = 3'd3;

  localparam logic [15:0] bp_cfg_reg_freeze_gp       = 16'h0008;
  localparam logic [15:0] bp_cfg_reg_npc_gp          = 16'h0010;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp  = 16'h0022;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp  = 16'h0043;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp     = 16'h0081;
  localparam logic [15:0] ucode_reg_base_lp          = 16'h8000;

  localparam logic [cfg_data_width_p-1:0] e_cce_mode_normal = 'd1;
  localparam logic [cfg_data_width_p-1:0] e_lce_mode_normal = 'd1;

  localparam logic [ucode_addr_width_lp-1:0] ucode_last_lp =
    ucode_addr_width_lp'(ucode_entries_p - 1);

  typedef enum logic [3:0] {
    e_idle, e_freeze, e_ucode, e_cce_mode, e_ic_mode,
    e_dc_mode, e_npc_w, e_npc_r, e_unfreeze, e_done
  } state_e;

  state_e                          state_r, state_n;
  logic                            wait_r, wait_n;       // 0: SEND, 1: WAIT
  logic [ucode_addr_width_lp-1:0]  ucode_cnt_r, ucode_cnt_n;
  logic                            error_r, error_n;

  logic [mt_width_lp-1:0]          cmd_type;
  logic [15:0]                     cmd_reg;
  logic [cfg_data_width_p-1:0]     cmd_data;
  logic [mt_width_lp-1:0]          resp_type;
  logic                            in_cmd_state;
  logic                            unused_resp_bits;

  assign resp_type        = mem_if.mem_resp[msg_width_lp-1 -: mt_width_lp];
  assign unused_resp_bits = ^mem_if.mem_resp[msg_width_lp-mt_width_lp-1:39];
  assign in_cmd_state     = (state_r != e_idle) && (state_r != e_done);

  // Command fields are a pure function of state and ucode index, so the
  // message cannot change while it waits for the handshake.
  always_comb begin
    cmd_type = e_cce_mem_uc_wr;
    cmd_reg  = '0;
    cmd_data = '0;
    case (state_r)
      e_freeze:   begin cmd_reg = bp_cfg_reg_freeze_gp;      cmd_data = 'd1; end
      e_ucode:    begin
        cmd_reg  = ucode_reg_base_lp + 16'(ucode_cnt_r);
        cmd_data = cfg_data_width_p'(ucode_data_i);
      end
      e_cce_mode: begin cmd_reg = bp_cfg_reg_cce_mode_gp;    cmd_data = e_cce_mode_normal; end
      e_ic_mode:  begin cmd_reg = bp_cfg_reg_icache_mode_gp; cmd_data = e_lce_mode_normal; end
      e_dc_mode:  begin cmd_reg = bp_cfg_reg_dcache_mode_gp; cmd_data = e_lce_mode_normal; end
      e_npc_w:    begin cmd_reg = bp_cfg_reg_npc_gp;         cmd_data = cfg_data_width_p'(npc_boot_p); end
      e_npc_r:    begin cmd_reg = bp_cfg_reg_npc_gp;         cmd_type = e_cce_mem_uc_rd; end
      e_unfreeze: begin cmd_reg = bp_cfg_reg_freeze_gp;      cmd_data = '0; end
      default:    begin cmd_reg = '0; end
    endcase
  end

  assign mem_if.mem_cmd = {cmd_type,
                           cfg_base_addr_p | paddr_width_p'(cmd_reg),
                           e_mem_msg_size_8,
                           {payload_width_lp{1'b0}},
                           cmd_data};

  // Sequencer: SEND/WAIT per command, response checking, stray-response handling
  always_comb begin
    state_n              = state_r;
    wait_n               = wait_r;
    ucode_cnt_n          = ucode_cnt_r;
    error_n              = error_r;
    mem_if.mem_cmd_v     = 1'b0;
    mem_if.mem_resp_yumi = 1'b0;

    if (!in_cmd_state) begin
      if (start_i) begin
        state_n     = e_freeze;
        wait_n      = 1'b0;
        ucode_cnt_n = '0;
        error_n     = 1'b0;
      end
      if (mem_if.mem_resp_v) begin
        mem_if.mem_resp_yumi = 1'b1;
        error_n              = 1'b1;
      end
    end else if (!wait_r) begin
      mem_if.mem_cmd_v = 1'b1;
      if (mem_if.mem_cmd_ready) wait_n = 1'b1;
      // Nothing is outstanding yet, so any response here is stray.
      if (mem_if.mem_resp_v) begin
        mem_if.mem_resp_yumi = 1'b1;
        error_n              = 1'b1;
      end
    end else if (mem_if.mem_resp_v) begin
      mem_if.mem_resp_yumi = 1'b1;
      wait_n               = 1'b0;
      if (resp_type != cmd_type) error_n = 1'b1;
      if ((state_r == e_npc_r) && (mem_if.mem_resp[38:0] != npc_boot_p)) error_n = 1'b1;
      if ((state_r == e_ucode) && (ucode_cnt_r != ucode_last_lp)) begin
        ucode_cnt_n = ucode_cnt_r + 1'b1;
      end else begin
        ucode_cnt_n = '0;
        case (state_r)
          e_freeze:   state_n = skip_ucode_p ? e_cce_mode : e_ucode;
          e_ucode:    state_n = e_cce_mode;
          e_cce_mode: state_n = e_ic_mode;
          e_ic_mode:  state_n = e_dc_mode;
          e_dc_mode:  state_n = e_npc_w;
          e_npc_w:    state_n = e_npc_r;
          e_npc_r:    state_n = e_unfreeze;
          e_unfreeze: state_n = e_done;
          default:    state_n = e_idle;
        endcase
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      wait_r      <= 1'b0;
      ucode_cnt_r <= '0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_n;
      wait_r      <= wait_n;
      ucode_cnt_r <= ucode_cnt_n;
      error_r     <= error_n;
    end
  end

  assign ucode_addr_o = ucode_cnt_r;
  assign busy_o       = in_cmd_state;
  assign done_o       = (state_r == e_done);
  assign error_o      = error_r;

endmodule
